// File: rtl/oc8051_int_seq_pkg.sv
// Shared types and constants for the 8051 interrupt entry/exit sequencer.
package oc8051_int_seq_pkg;

   typedef enum logic [2:0] {
      OC8051_IS_IDLE    = 3'd0,
      OC8051_IS_PUSH_LO = 3'd1,
      OC8051_IS_PUSH_HI = 3'd2,
      OC8051_IS_JUMP    = 3'd3,
      OC8051_IS_POP_HI  = 3'd4,
      OC8051_IS_POP_LO  = 3'd5,
      OC8051_IS_RET     = 3'd6
   } oc8051_is_state_e;

   // The 8051 pushes the return PC low byte first, so it pops high byte first.
   localparam bit OC8051_IS_PUSH_LO_FIRST = 1'b1;

   typedef struct packed {
      logic       req;
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
   } oc8051_mem_cmd_t;

   function automatic logic [7:0] oc8051_push_byte(input logic [15:0] ret_pc,
                                                   input logic        first_slot);
      return (first_slot == OC8051_IS_PUSH_LO_FIRST) ? ret_pc[7:0] : ret_pc[15:8];
   endfunction

endpackage

// File: rtl/oc8051_int_seq_pend.sv
// Pending-vector holder: captures the controller's single-cycle vector pulse
// until the sequencer consumes it on the jump.
module oc8051_int_pend (
   input  logic       clk,
   input  logic       rst,
   input  logic       intr,
   input  logic [7:0] int_vec,
   input  logic       clr,
   output logic       pend,
   output logic [7:0] pend_vec
);

   logic       pend_d, pend_q;
   logic [7:0] vec_d, vec_q;

   // A capture in the clearing cycle wins, so a late higher-priority vector is kept.
   always_comb begin
      pend_d = pend_q;
      vec_d  = vec_q;
      if (clr) pend_d = 1'b0;
      if (intr) begin
         pend_d = 1'b1;
         vec_d  = int_vec;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q <= 1'b0;
         vec_q  <= 8'h00;
      end else begin
         pend_q <= pend_d;
         vec_q  <= vec_d;
      end
   end

   assign pend     = pend_q;
   assign pend_vec = vec_q;

endmodule

// File: rtl/oc8051_int_seq.sv
// Interrupt entry/exit sequencer: stacks the return PC and vectors on entry,
// unstacks it on RETI, and stalls the core while doing so.
module oc8051_int_seq
   import oc8051_int_seq_pkg::*;
#(
   parameter logic [7:0] VEC_HI = 8'h00,
   parameter int         PC_W   = 16    // byte split below assumes 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            intr,
   input  logic [7:0]      int_vec,
   input  logic            instr_bnd,
   input  logic            reti_req,
   input  logic [PC_W-1:0] pc,
   input  logic [7:0]      sp,
   output logic            mem_req,
   output logic            mem_we,
   output logic [7:0]      mem_addr,
   output logic [7:0]      mem_wdata,
   input  logic            mem_ack,
   input  logic [7:0]      mem_rdata,
   output logic            sp_load,
   output logic [7:0]      sp_new,
   output logic            pc_load,
   output logic [PC_W-1:0] pc_new,
   output logic            ack,
   output logic            reti,
   output logic            stall,
   output logic            busy
);

   oc8051_is_state_e state_d, state_q;
   logic [PC_W-1:0]  ret_pc_d, ret_pc_q;
   logic [7:0]       sp_w_d, sp_w_q;
   logic [7:0]       sp_inc, sp_dec;
   logic             pend;
   logic [7:0]       pend_vec;
   logic             pend_clr;
   oc8051_mem_cmd_t  cmd;

   oc8051_int_pend u_pend (
      .clk      (clk),
      .rst      (rst),
      .intr     (intr),
      .int_vec  (int_vec),
      .clr      (pend_clr),
      .pend     (pend),
      .pend_vec (pend_vec)
   );

   // SP arithmetic wraps modulo 256 by width.
   assign sp_inc = sp_w_q + 8'd1;
   assign sp_dec = sp_w_q - 8'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= OC8051_IS_IDLE;
         ret_pc_q <= '0;
         sp_w_q   <= 8'h00;
      end else begin
         state_q  <= state_d;
         ret_pc_q <= ret_pc_d;
         sp_w_q   <= sp_w_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ret_pc_d = ret_pc_q;
      sp_w_d   = sp_w_q;
      case (state_q)
         OC8051_IS_IDLE: begin
            // RETI outranks a waiting entry; the entry follows right after RET.
            if (reti_req) begin
               state_d = OC8051_IS_POP_HI;
               sp_w_d  = sp;
            end else if (pend && instr_bnd) begin
               state_d  = OC8051_IS_PUSH_LO;
               ret_pc_d = pc;
               sp_w_d   = sp;
            end
         end
         OC8051_IS_PUSH_LO: begin
            if (mem_ack) begin
               sp_w_d  = sp_inc;
               state_d = OC8051_IS_PUSH_HI;
            end
         end
         OC8051_IS_PUSH_HI: begin
            if (mem_ack) begin
               sp_w_d  = sp_inc;
               state_d = OC8051_IS_JUMP;
            end
         end
         OC8051_IS_JUMP: state_d = OC8051_IS_IDLE;
         OC8051_IS_POP_HI: begin
            if (mem_ack) begin
               ret_pc_d[15:8] = mem_rdata;
               sp_w_d         = sp_dec;
               state_d        = OC8051_IS_POP_LO;
            end
         end
         OC8051_IS_POP_LO: begin
            if (mem_ack) begin
               ret_pc_d[7:0] = mem_rdata;
               sp_w_d        = sp_dec;
               state_d       = OC8051_IS_RET;
            end
         end
         OC8051_IS_RET: state_d = OC8051_IS_IDLE;
         default:       state_d = OC8051_IS_IDLE;
      endcase
   end

   always_comb begin
      cmd      = '0;
      sp_load  = 1'b0;
      sp_new   = 8'h00;
      pc_load  = 1'b0;
      pc_new   = '0;
      ack      = 1'b0;
      reti     = 1'b0;
      pend_clr = 1'b0;
      stall    = 1'b1;
      case (state_q)
         OC8051_IS_IDLE: stall = (pend & instr_bnd) | reti_req;
         OC8051_IS_PUSH_LO: begin
            cmd.req   = 1'b1;
            cmd.we    = 1'b1;
            cmd.addr  = sp_inc;
            cmd.wdata = oc8051_push_byte(ret_pc_q, 1'b1);
         end
         OC8051_IS_PUSH_HI: begin
            cmd.req   = 1'b1;
            cmd.we    = 1'b1;
            cmd.addr  = sp_inc;
            cmd.wdata = oc8051_push_byte(ret_pc_q, 1'b0);
         end
         OC8051_IS_JUMP: begin
            pc_load  = 1'b1;
            pc_new   = {VEC_HI, pend_vec};
            sp_load  = 1'b1;
            sp_new   = sp_w_q;
            ack      = 1'b1;
            pend_clr = 1'b1;
         end
         OC8051_IS_POP_HI, OC8051_IS_POP_LO: begin
            cmd.req  = 1'b1;
            cmd.addr = sp_w_q;
         end
         OC8051_IS_RET: begin
            pc_load = 1'b1;
            pc_new  = ret_pc_q;
            sp_load = 1'b1;
            sp_new  = sp_w_q;
            reti    = 1'b1;
         end
         default: stall = 1'b0;
      endcase
   end

   assign mem_req   = cmd.req;
   assign mem_we    = cmd.we;
   assign mem_addr  = cmd.addr;
   assign mem_wdata = cmd.wdata;
   assign busy      = (state_q != OC8051_IS_IDLE) | pend;

endmodule

// File: tb/tb_oc8051_int_seq.sv
// Bench for oc8051_int_seq: fixed vector table, corner sequences, and random
// traffic against a transaction-level model of the stack sequencer.
module tb_oc8051_int_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        intr = 1'b0, instr_bnd = 1'b0, reti_req = 1'b0, mem_ack = 1'b0;
   logic [7:0]  int_vec = 8'h00, sp = 8'h00, mem_rdata = 8'h00;
   logic [15:0] pc = 16'h0000;
   logic        mem_req, mem_we, sp_load, pc_load, ack, reti, stall, busy;
   logic [7:0]  mem_addr, mem_wdata, sp_new;
   logic [15:0] pc_new;

   always #5 clk = ~clk;

   oc8051_int_seq #(.VEC_HI(8'h00), .PC_W(16)) dut (
      .clk(clk), .rst(rst), .intr(intr), .int_vec(int_vec), .instr_bnd(instr_bnd),
      .reti_req(reti_req), .pc(pc), .sp(sp), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .sp_load(sp_load), .sp_new(sp_new), .pc_load(pc_load), .pc_new(pc_new),
      .ack(ack), .reti(reti), .stall(stall), .busy(busy)
   );

   typedef struct packed {
      logic intr; logic [7:0] vec; logic bnd; logic rr; logic [15:0] pc; logic [7:0] sp; logic mack;
   } in_t;
   typedef struct packed {
      logic mem_req; logic mem_we; logic [7:0] mem_addr; logic [7:0] mem_wdata;
      logic sp_load; logic [7:0] sp_new; logic pc_load; logic [15:0] pc_new;
      logic ack; logic reti; logic stall; logic busy;
   } out_t;
   typedef struct { in_t i; out_t o; string name; } vec_t;

   typedef enum { K_WR, K_RD, K_JMP, K_RET } kind_e;
   typedef struct { kind_e k; logic [7:0] addr; logic [7:0] data; logic [7:0] sp; } op_t;

   // Model: a queue of outstanding stack operations; empty means idle.
   op_t        plan[$];
   logic [7:0] rd_b[$];
   logic [7:0] ram[256];
   logic       m_pend = 1'b0;
   logic [7:0] m_vec = 8'h00;

   int n_tests = 0, n_fail = 0, cyc = 0;
   int ack_cnt = 0, ack_cyc = 0, reti_cyc = 0;
   logic [15:0] last_jmp_pc, last_ret_pc;
   logic [7:0]  last_jmp_sp, last_ret_sp;
   logic [7:0]  acc_addr[$];

   function automatic in_t iv(logic i, logic [7:0] v, logic b, logic r, logic [15:0] p,
                              logic [7:0] s, logic a);
      return '{i, v, b, r, p, s, a};
   endfunction

   function automatic out_t ov(logic rq, logic we, logic [7:0] ad, logic [7:0] wd, logic sl,
                               logic [7:0] sn, logic pl, logic [15:0] pn, logic ak, logic rt,
                               logic st, logic bz);
      return '{rq, we, ad, wd, sl, sn, pl, pn, ak, rt, st, bz};
   endfunction

   function automatic out_t care_of(out_t e);
      out_t c = '1;
      if (!e.mem_req) c.mem_addr = '0;
      if (!(e.mem_req && e.mem_we)) c.mem_wdata = '0;
      if (!e.sp_load) c.sp_new = '0;
      if (!e.pc_load) c.pc_new = '0;
      return c;
   endfunction

   function automatic out_t model_out(in_t i);
      out_t e = '0;
      if (plan.size() == 0) begin
         e.stall = (m_pend & i.bnd) | i.rr;
         e.busy  = m_pend;
      end else begin
         e.stall = 1'b1;
         e.busy  = 1'b1;
         case (plan[0].k)
            K_WR:  begin e.mem_req = 1'b1; e.mem_we = 1'b1; e.mem_addr = plan[0].addr;
                         e.mem_wdata = plan[0].data; end
            K_RD:  begin e.mem_req = 1'b1; e.mem_addr = plan[0].addr; end
            K_JMP: begin e.pc_load = 1'b1; e.pc_new = {8'h00, m_vec}; e.sp_load = 1'b1;
                         e.sp_new = plan[0].sp; e.ack = 1'b1; end
            default: begin e.pc_load = 1'b1; e.pc_new = {rd_b[0], rd_b[1]}; e.sp_load = 1'b1;
                         e.sp_new = plan[0].sp; e.reti = 1'b1; end
         endcase
      end
      return e;
   endfunction

   task automatic model_update(in_t i, logic r);
      logic       clr = 1'b0;
      logic [7:0] s1, s2, m1, m2;
      if (r) begin
         plan.delete(); rd_b.delete(); m_pend = 1'b0; m_vec = 8'h00;
         return;
      end
      s1 = i.sp + 8'd1; s2 = i.sp + 8'd2; m1 = i.sp - 8'd1; m2 = i.sp - 8'd2;
      if (plan.size() != 0) begin
         case (plan[0].k)
            K_WR:  if (i.mack) begin ram[plan[0].addr] = plan[0].data; void'(plan.pop_front()); end
            K_RD:  if (i.mack) begin rd_b.push_back(ram[plan[0].addr]); void'(plan.pop_front()); end
            K_JMP: begin clr = 1'b1; void'(plan.pop_front()); end
            default: begin rd_b.delete(); void'(plan.pop_front()); end
         endcase
      end else if (i.rr) begin
         rd_b.delete();
         plan.push_back('{K_RD, i.sp, 8'h00, 8'h00});
         plan.push_back('{K_RD, m1, 8'h00, 8'h00});
         plan.push_back('{K_RET, 8'h00, 8'h00, m2});
      end else if (m_pend && i.bnd) begin
         plan.push_back('{K_WR, s1, i.pc[7:0], 8'h00});
         plan.push_back('{K_WR, s2, i.pc[15:8], 8'h00});
         plan.push_back('{K_JMP, 8'h00, 8'h00, s2});
      end
      if (clr) m_pend = 1'b0;
      if (i.intr) begin m_pend = 1'b1; m_vec = i.vec; end
   endtask

   task automatic chk(string name, logic [47:0] got, logic [47:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic cycle(input in_t i, input logic r, input string tag, output out_t act);
      out_t e, c;
      @(negedge clk);
      rst = r; intr = i.intr; int_vec = i.vec; instr_bnd = i.bnd; reti_req = i.rr;
      pc = i.pc; sp = i.sp; mem_ack = i.mack;
      if (plan.size() != 0 && plan[0].k == K_RD) mem_rdata = ram[plan[0].addr];
      else mem_rdata = 8'($urandom);
      #1;
      act = {mem_req, mem_we, mem_addr, mem_wdata, sp_load, sp_new, pc_load, pc_new,
             ack, reti, stall, busy};
      e = model_out(i);
      c = care_of(e);
      n_tests++;
      if (((act ^ e) & c) != '0) begin
         n_fail++;
         $display("FAIL %s cyc %0d: got %h expected %h", tag, cyc, act, e);
      end
      if (act.ack) begin
         ack_cnt++; ack_cyc = cyc; last_jmp_pc = act.pc_new; last_jmp_sp = act.sp_new;
      end
      if (act.reti) begin
         reti_cyc = cyc; last_ret_pc = act.pc_new; last_ret_sp = act.sp_new;
      end
      if (act.mem_req && i.mack) acc_addr.push_back(act.mem_addr);
      model_update(i, r);
      cyc++;
   endtask

   vec_t tbl[11];
   out_t act;
   in_t  idle_in;

   initial begin
      for (int k = 0; k < 256; k++) ram[k] = 8'($urandom);
      idle_in = iv(0, 8'h00, 0, 0, 16'h0000, 8'h00, 1);

      // Reset and reset-state check
      cycle(idle_in, 1'b1, "reset", act);
      cycle(idle_in, 1'b1, "reset", act);
      cycle(idle_in, 1'b0, "post_reset", act);
      chk("reset_outputs_zero", 48'(act), 48'h0);

      // Entry then RETI, cycle by cycle
      tbl[0]  = '{iv(1, 8'h0B, 0, 0, 16'h1234, 8'h07, 1), '0, "t1_intr"};
      tbl[1]  = '{iv(0, 8'h00, 1, 0, 16'h1234, 8'h07, 1), ov(0,0,0,0,0,0,0,0,0,0,1,1), "t1_bnd"};
      tbl[2]  = '{iv(0, 8'h00, 0, 0, 16'h1234, 8'h07, 1), ov(1,1,8'h08,8'h34,0,0,0,0,0,0,1,1), "t1_wr_lo"};
      tbl[3]  = '{iv(0, 8'h00, 0, 0, 16'h1234, 8'h07, 1), ov(1,1,8'h09,8'h12,0,0,0,0,0,0,1,1), "t1_wr_hi"};
      tbl[4]  = '{iv(0, 8'h00, 0, 0, 16'h1234, 8'h07, 1), ov(0,0,0,0,1,8'h09,1,16'h000B,1,0,1,1), "t1_jump"};
      tbl[5]  = '{iv(0, 8'h00, 0, 0, 16'h1234, 8'h07, 1), '0, "t1_idle"};
      tbl[6]  = '{iv(0, 8'h00, 0, 1, 16'h0000, 8'h09, 1), ov(0,0,0,0,0,0,0,0,0,0,1,0), "t2_reti"};
      tbl[7]  = '{iv(0, 8'h00, 0, 0, 16'h0000, 8'h09, 1), ov(1,0,8'h09,0,0,0,0,0,0,0,1,1), "t2_rd_hi"};
      tbl[8]  = '{iv(0, 8'h00, 0, 0, 16'h0000, 8'h09, 1), ov(1,0,8'h08,0,0,0,0,0,0,0,1,1), "t2_rd_lo"};
      tbl[9]  = '{iv(0, 8'h00, 0, 0, 16'h0000, 8'h09, 1), ov(0,0,0,0,1,8'h07,1,16'h1234,0,1,1,1), "t2_ret"};
      tbl[10] = '{iv(0, 8'h00, 0, 0, 16'h0000, 8'h09, 1), '0, "t2_idle"};
      for (int k = 0; k < 11; k++) begin
         cycle(tbl[k].i, 1'b0, tbl[k].name, act);
         chk(tbl[k].name, 48'(act & care_of(tbl[k].o)), 48'(tbl[k].o));
      end

      // Delayed boundary with overwrite: one entry, to the later vector
      ack_cnt = 0;
      cycle(iv(1, 8'h03, 0, 0, 16'h2222, 8'h30, 1), 1'b0, "t3", act);
      cycle(iv(0, 8'h00, 0, 0, 16'h2222, 8'h30, 1), 1'b0, "t3", act);
      cycle(iv(1, 8'h13, 0, 0, 16'h2222, 8'h30, 1), 1'b0, "t3", act);
      cycle(iv(0, 8'h00, 0, 0, 16'h2222, 8'h30, 1), 1'b0, "t3", act);
      cycle(iv(0, 8'h00, 0, 0, 16'h2222, 8'h30, 1), 1'b0, "t3", act);
      for (int k = 0; k < 8; k++)
         cycle(iv(0, 8'h00, 1, 0, 16'h2222, 8'h30, 1), 1'b0, "t3", act);
      chk("t3_ack_once", 48'(ack_cnt), 48'd1);
      chk("t3_vector", 48'(last_jmp_pc), 48'h0013);

      // Three wait states per access: 9 cycles from boundary to ack
      begin
         int w = 0, n = 0;
         logic a, done = 1'b0;
         cycle(iv(1, 8'h2B, 0, 0, 16'hBEEF, 8'h40, 0), 1'b0, "t4", act);
         cycle(iv(0, 8'h00, 1, 0, 16'hBEEF, 8'h40, 0), 1'b0, "t4", act);
         for (int k = 0; k < 20 && !done; k++) begin
            a = (w == 3);
            cycle(iv(0, 8'h00, 0, 0, 16'h0000, 8'h00, a), 1'b0, "t4", act);
            n++;
            if (act.ack) done = 1'b1;
            w = a ? 0 : w + 1;
         end
         chk("t4_entry_cycles", 48'(n), 48'd9);
         chk("t4_vector", 48'(last_jmp_pc), 48'h002B);
         chk("t4_sp_new", 48'(last_jmp_sp), 48'h42);
         chk("t4_ram", 48'({ram[8'h41], ram[8'h42]}), 48'hEFBE);
      end

      // Wrap and priority: RETI first, then entry right after RET
      ram[8'hFF] = 8'hAB; ram[8'hFE] = 8'hCD;
      cycle(iv(1, 8'h23, 0, 0, 16'h5555, 8'hFF, 1), 1'b0, "t5", act);
      acc_addr.delete();
      cycle(iv(0, 8'h00, 1, 1, 16'h5555, 8'hFF, 1), 1'b0, "t5", act);
      for (int k = 0; k < 8; k++)
         cycle(iv(0, 8'h00, 1, 0, 16'h6789, 8'hFE, 1), 1'b0, "t5", act);
      chk("t5_ret_pc", 48'(last_ret_pc), 48'hABCD);
      chk("t5_ret_sp", 48'(last_ret_sp), 48'hFD);
      chk("t5_jmp_sp", 48'(last_jmp_sp), 48'h00);
      chk("t5_jmp_pc", 48'(last_jmp_pc), 48'h0023);
      chk("t5_back_to_back", 48'(ack_cyc - reti_cyc), 48'd4);
      chk("t5_naccess", 48'(acc_addr.size()), 48'd4);
      if (acc_addr.size() == 4)
         chk("t5_addrs", 48'({acc_addr[0], acc_addr[1], acc_addr[2], acc_addr[3]}), 48'hFFFEFF00);

      // Reset during PUSH_HI
      ack_cnt = 0;
      cycle(iv(1, 8'h31, 0, 0, 16'h1111, 8'h20, 1), 1'b0, "t6", act);
      cycle(iv(0, 8'h00, 1, 0, 16'h1111, 8'h20, 1), 1'b0, "t6", act);
      cycle(iv(0, 8'h00, 0, 0, 16'h1111, 8'h20, 1), 1'b0, "t6", act);
      cycle(iv(0, 8'h00, 0, 0, 16'h1111, 8'h20, 0), 1'b1, "t6_rst", act);
      chk("t6_in_push_hi", 48'({act.mem_req, act.mem_addr}), 48'h122);
      for (int k = 0; k < 4; k++) begin
         cycle(iv(0, 8'h00, 0, 0, 16'h1111, 8'h20, 1), 1'b0, "t6_after", act);
         chk("t6_zero", 48'(act), 48'h0);
      end
      chk("t6_no_ack", 48'(ack_cnt), 48'd0);

      // Random traffic
      for (int k = 0; k < 3000; k++) begin
         in_t  r;
         logic rr;
         r.intr = ($urandom_range(0, 9) == 0);
         r.vec  = 8'($urandom);
         r.bnd  = ($urandom_range(0, 2) == 0);
         r.rr   = (plan.size() == 0) && ($urandom_range(0, 11) == 0);
         r.pc   = 16'($urandom);
         r.sp   = 8'($urandom);
         r.mack = ($urandom_range(0, 9) < 6);
         rr     = ($urandom_range(0, 499) == 0);
         cycle(r, rr, "rand", act);
         if (act.ack && act.reti) chk("rand_ack_reti_excl", 48'd1, 48'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
